// File: rtl/keypad_scanner.sv
// keypad_scanner: column-scanned matrix keypad with frame debounce, multi-key rejection and auto-repeat.
module keypad_scanner #(
    parameter int N_ROW      = 4,
    parameter int N_COL      = 4,
    parameter int DIV        = 4,
    parameter int DEB        = 3,
    parameter int REP_FRAMES = 0,
    localparam int CODE_W    = (N_ROW * N_COL > 1) ? $clog2(N_ROW * N_COL) : 1
) (
    input  logic              IN_clk,
    input  logic              IN_reset,
    input  logic [N_ROW-1:0]  IN_row,
    output logic [N_COL-1:0]  OUT_col,
    output logic [CODE_W-1:0] OUT_code,
    output logic              OUT_valid,
    output logic              OUT_held,
    output logic              OUT_release,
    output logic              OUT_multi
);
    localparam int COL_W = (N_COL > 1) ? $clog2(N_COL) : 1;
    localparam int ROW_W = (N_ROW > 1) ? $clog2(N_ROW) : 1;
    localparam int DIV_W = $clog2(DIV);
    localparam int STB_W = $clog2(DEB + 1);
    localparam int REP_W = (REP_FRAMES > 0) ? $clog2(REP_FRAMES + 1) : 1;
    localparam logic [N_COL-1:0] COL0 = N_COL'(1) << (N_COL - 1);
    localparam logic [1:0] K_NONE = 2'd0, K_KEY = 2'd1, K_MULTI = 2'd2;

    typedef enum logic {S_IDLE, S_PRESSED} state_t;

    state_t              r_state, w_state_n;
    logic [COL_W-1:0]    r_col;
    logic [DIV_W-1:0]    r_dwell;
    logic [1:0]          r_cnt, r_pkind;
    logic [CODE_W-1:0]   r_first, r_pcode, r_code;
    logic [STB_W-1:0]    r_stable;
    logic [REP_W-1:0]    r_rep;
    logic                r_valid, r_release, r_multi;

    logic                w_smp, w_end, w_same, w_match, w_commit;
    logic [1:0]          w_col_cnt, w_cnt, w_kind;
    logic [ROW_W-1:0]    w_col_row;
    logic [CODE_W-1:0]   w_col_key, w_first, w_code_n;
    logic [STB_W-1:0]    w_stable;
    logic [REP_W-1:0]    w_rep_n;
    logic                w_valid_n, w_rel_n;

    assign w_smp = r_dwell == DIV_W'(DIV - 1);
    assign w_end = w_smp && r_col == COL_W'(N_COL - 1);

    // Pressed-key count saturates at 2: only none/one/many matters.
    always_comb begin
        w_col_cnt = 2'd0;
        w_col_row = '0;
        for (int r = N_ROW - 1; r >= 0; r--)
            if (IN_row[N_ROW-1-r]) begin
                w_col_cnt = (w_col_cnt == 2'd0) ? 2'd1 : 2'd2;
                w_col_row = ROW_W'(r);
            end
    end

    assign w_col_key = CODE_W'(w_col_row) * CODE_W'(N_COL) + CODE_W'(r_col);
    assign w_cnt     = (r_cnt == 2'd0) ? w_col_cnt : (w_col_cnt == 2'd0) ? r_cnt : 2'd2;
    assign w_first   = (r_cnt == 2'd0) ? w_col_key : r_first;
    assign w_kind    = (w_cnt == 2'd0) ? K_NONE : (w_cnt == 2'd1) ? K_KEY : K_MULTI;
    assign w_same    = w_kind == r_pkind && (w_kind != K_KEY || w_first == r_pcode);
    assign w_stable  = (w_kind == K_MULTI) ? '0 : !w_same ? STB_W'(1) :
                       (r_stable == STB_W'(DEB)) ? r_stable : r_stable + 1'b1;
    assign w_match   = r_state == S_PRESSED && w_kind == K_KEY && w_first == r_code;
    assign w_commit  = w_end && w_kind != K_MULTI && w_stable == STB_W'(DEB) &&
                       ((w_kind == K_NONE) ? r_state == S_PRESSED : !w_match);

    always_ff @(posedge IN_clk) begin
        if (IN_reset) begin
            r_col    <= '0;
            r_dwell  <= '0;
            r_cnt    <= '0;
            r_first  <= '0;
            r_pkind  <= K_NONE;
            r_pcode  <= '0;
            r_stable <= '0;
            r_multi  <= 1'b0;
        end else begin
            r_dwell <= w_smp ? '0 : r_dwell + 1'b1;
            if (w_smp) begin
                r_col   <= w_end ? '0 : r_col + 1'b1;
                r_cnt   <= w_end ? 2'd0 : w_cnt;
                r_first <= w_end ? '0 : w_first;
            end
            if (w_end) begin
                r_pkind  <= w_kind;
                r_pcode  <= w_first;
                r_stable <= w_stable;
                r_multi  <= w_kind == K_MULTI;
            end
        end
    end

    always_comb begin
        w_state_n = r_state;
        w_code_n  = r_code;
        w_valid_n = 1'b0;
        w_rel_n   = 1'b0;
        w_rep_n   = r_rep;
        if (w_commit && w_kind == K_KEY) begin
            w_state_n = S_PRESSED;
            w_code_n  = w_first;
            w_valid_n = 1'b1;
            w_rep_n   = '0;
        end else if (w_commit) begin
            w_state_n = S_IDLE;
            w_rel_n   = 1'b1;
        end else if (REP_FRAMES > 0 && w_end && w_match && w_stable == STB_W'(DEB)) begin
            w_valid_n = r_rep == REP_W'(REP_FRAMES - 1);
            w_rep_n   = w_valid_n ? '0 : r_rep + 1'b1;
        end
    end

    always_ff @(posedge IN_clk) begin
        if (IN_reset) begin
            r_state   <= S_IDLE;
            r_code    <= '0;
            r_valid   <= 1'b0;
            r_release <= 1'b0;
            r_rep     <= '0;
        end else begin
            r_state   <= w_state_n;
            r_code    <= w_code_n;
            r_valid   <= w_valid_n;
            r_release <= w_rel_n;
            r_rep     <= w_rep_n;
        end
    end

    assign OUT_col     = COL0 >> r_col;
    assign OUT_code    = r_code;
    assign OUT_valid   = r_valid;
    assign OUT_held    = r_state == S_PRESSED;
    assign OUT_release = r_release;
    assign OUT_multi   = r_multi;
endmodule
